dsp_fir_tap_sequencer: RTL

- Upstream controller for the 20x18x64 DSP primitive wrapper in FIR mode.
- Accepts input samples over a valid/ready stream and keeps a NUM_TAPS-deep sample delay line plus a writable coefficient bank.
- Serially drives one (coefficient, sample) pair per cycle into the DSP operand and control ports, then captures the accumulated z result and presents it on an output valid/ready stream.

---
 rtl/dsp_fir_seq_pkg.sv | 21 ++
 rtl/dsp_fir_seq_delay_line.sv | 39 +++
 rtl/dsp_fir_tap_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_fir_seq_pkg.sv
// Shared definitions for the FIR tap sequencer.
//   state_e  : sequencer FSM states
//   FB_*     : DSP feedback selector codes (accumulate / load fresh)
//   A_W/B_W/Z_W : DSP operand and result widths
package dsp_fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam logic [2:0] FB_ACCUM = 3'b000;
    localparam logic [2:0] FB_LOAD  = 3'b001;

    localparam int unsigned A_W = 20;
    localparam int unsigned B_W = 18;
    localparam int unsigned Z_W = 38;

endpackage

// File: rtl/dsp_fir_seq_delay_line.sv
// Sample delay line for the FIR tap sequencer.
//   clk_i      : clock, rising edge
//   clr_i      : synchronous clear of every tap (active high)
//   shift_en_i : shift data_i into tap 0, every tap k takes tap k-1
//   data_i     : incoming sample
//   rd_addr_i  : tap index to read
//   rd_data_o  : sample held in tap rd_addr_i (combinational read)
module dsp_fir_seq_delay_line
    import dsp_fir_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic           shift_en_i,
    input  logic [B_W-1:0] data_i,
    input  logic [AW-1:0]  rd_addr_i,
    output logic [B_W-1:0] rd_data_o
);

    logic [B_W-1:0] taps_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taps_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            taps_q[0] <= data_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign rd_data_o = taps_q[rd_addr_i];

endmodule

// File: rtl/dsp_fir_tap_sequencer.sv
// FIR tap sequencer feeding a 20x18x64 DSP primitive in accumulate mode.
// Accepts one sample per pass, walks NUM_TAPS (coeff, sample) pairs onto the
// DSP ports, waits for the accumulated sum and holds it on the output stream.
//
// Ports:
//   clock_i, reset_i             : clock, synchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o : input sample stream (accepted in IDLE only)
//   coeff_wr_en/addr/data_i      : coefficient bank write port (any state)
//   dsp_a_o, dsp_b_o             : coefficient / sample operands to the DSP
//   dsp_load_acc_o, dsp_feedback_o : DSP accumulate enable and feedback select
//   dsp_z_i                      : DSP accumulated result
//   m_data_o/m_valid_o/m_ready_i : result stream (no skid buffer)
//   busy_o                       : high whenever not IDLE
//   overflow_o                   : result was clipped (qualified by m_valid_o)
//
// Build option: define DSP_FIR_TAP_SEQUENCER_SAT_EN to clip the captured result
// to a signed OUT_WIDTH range; otherwise the raw DSP result is passed through.
module dsp_fir_tap_sequencer
    import dsp_fir_seq_pkg::*;
#(
    parameter int unsigned NUM_TAPS    = 8,
    parameter int unsigned DSP_LATENCY = 1,
    parameter int unsigned OUT_WIDTH   = 20
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [B_W-1:0]              s_data_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic                        coeff_wr_en_i,
    input  logic [$clog2(NUM_TAPS)-1:0] coeff_wr_addr_i,
    input  logic [A_W-1:0]              coeff_wr_data_i,
    output logic [A_W-1:0]              dsp_a_o,
    output logic [B_W-1:0]              dsp_b_o,
    output logic                        dsp_load_acc_o,
    output logic [2:0]                  dsp_feedback_o,
    input  logic [Z_W-1:0]              dsp_z_i,
    output logic [Z_W-1:0]              m_data_o,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic                        busy_o,
    output logic                        overflow_o
);

    localparam int unsigned AW = $clog2(NUM_TAPS);
    localparam int unsigned DW = $clog2(DSP_LATENCY + 2);
    localparam logic [AW-1:0] K_LAST = AW'(NUM_TAPS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DSP_LATENCY);

    if (NUM_TAPS < 2 || NUM_TAPS > 32) begin : g_bad_taps
        $error("NUM_TAPS must be in 2..32");
    end
    if (DSP_LATENCY < 1) begin : g_bad_lat
        $error("DSP_LATENCY must be at least 1");
    end
    if (OUT_WIDTH < 2 || OUT_WIDTH > Z_W) begin : g_bad_ow
        $error("OUT_WIDTH must be in 2..38");
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            m_valid_q, m_valid_d;
    logic [Z_W-1:0]  m_data_q, m_data_d;
    logic            ovf_q, ovf_d;
    logic [A_W-1:0]  coeff_q [NUM_TAPS];
    logic [B_W-1:0]  sample_rd;
    logic            accept;
    logic [Z_W-1:0]  z_proc;
    logic            z_ovf;

    assign accept = (state_q == IDLE) && s_valid_i;

    dsp_fir_seq_delay_line #(
        .DEPTH (NUM_TAPS)
    ) u_delay (
        .clk_i      (clock_i),
        .clr_i      (reset_i),
        .shift_en_i (accept),
        .data_i     (s_data_i),
        .rd_addr_i  (k_q),
        .rd_data_o  (sample_rd)
    );

    // Writes land at the edge, so a RUN read of the same tap in that cycle
    // still sees the previous coefficient.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (coeff_wr_en_i && (32'(coeff_wr_addr_i) < NUM_TAPS)) begin
            coeff_q[coeff_wr_addr_i] <= coeff_wr_data_i;
        end
    end

`ifdef DSP_FIR_TAP_SEQUENCER_SAT_EN
    localparam logic [Z_W-1:0] SAT_MAX = {{(Z_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [Z_W-1:0] SAT_MIN = {{(Z_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // In range iff every bit from the OUT_WIDTH sign bit upward agrees.
    logic [Z_W-OUT_WIDTH:0] z_upper;
    assign z_upper = dsp_z_i[Z_W-1:OUT_WIDTH-1];

    always_comb begin
        z_proc = dsp_z_i;
        z_ovf  = 1'b0;
        if (!((&z_upper) || (~|z_upper))) begin
            z_ovf  = 1'b1;
            z_proc = dsp_z_i[Z_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign z_proc = dsp_z_i;
    assign z_ovf  = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            k_q       <= '0;
            drain_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // DRAIN runs one cycle beyond DSP_LATENCY so the capture edge samples
    // a fully settled z after the final accumulate.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        drain_d        = drain_q;
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        ovf_d          = ovf_q;
        s_ready_o      = 1'b0;
        dsp_a_o        = '0;
        dsp_b_o        = '0;
        dsp_load_acc_o = 1'b0;
        dsp_feedback_o = FB_ACCUM;

        case (state_q)
            IDLE: begin
                s_ready_o = 1'b1;
                if (s_valid_i) begin
                    state_d = RUN;
                    k_d     = '0;
                end
            end
            RUN: begin
                dsp_a_o        = coeff_q[k_q];
                dsp_b_o        = sample_rd;
                dsp_load_acc_o = 1'b1;
                dsp_feedback_o = (k_q == '0) ? FB_LOAD : FB_ACCUM;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == D_LAST) begin
                    m_data_d  = z_proc;
                    ovf_d     = z_ovf;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            HOLD: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_data_o   = m_data_q;
    assign m_valid_o  = m_valid_q;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != IDLE);

endmodule
